// File: rtl/wallace_pkg.sv
// Elaboration-time helpers for the pipelined Wallace multiplier: tree sizing,
// stage split point and the Baugh-Wooley correction constant.
package wallace_pkg;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Partial-product rows plus one row for the signed-mode correction constant.
  function automatic int pp_rows(input int w);
    return w + 1;
  endfunction

  function automatic int csa_rows_out(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int rows_after(input int n, input int layers);
    int r;
    r = n;
    for (int i = 0; i < layers; i++) r = csa_rows_out(r);
    return r;
  endfunction

  function automatic int wallace_layers(input int w);
    int r;
    int k;
    r = pp_rows(w);
    k = 0;
    while (r > 2) begin
      r = csa_rows_out(r);
      k++;
    end
    return k;
  endfunction

  // Stage 1 keeps reducing until at most half the original height remains.
  function automatic int split_layer(input int w);
    int r;
    int k;
    int lim;
    r   = pp_rows(w);
    lim = (r + 1) / 2;
    k   = 0;
    while (r > lim) begin
      r = csa_rows_out(r);
      k++;
    end
    return k;
  endfunction

  function automatic logic [63:0] bw_const(input int w);
    logic [63:0] c;
    c = 64'd0;
    c[w] = 1'b1;
    c[2*w-1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/wallace_csa_layer.sv
// One combinational 3:2 compression layer: each group of three rows becomes a
// sum row and a left-shifted carry row; leftover rows pass straight through.
module wallace_csa_layer
  import wallace_pkg::*;
#(
  parameter int ROWS_IN = 3,
  parameter int COL_W   = 16
) (
  input  logic [ROWS_IN*COL_W-1:0]               rows_i,
  output logic [csa_rows_out(ROWS_IN)*COL_W-1:0] rows_o
);

  localparam int GROUPS = ROWS_IN / 3;
  localparam int LEFT   = ROWS_IN % 3;

  for (genvar g = 0; g < GROUPS; g++) begin : g_fa
    logic [COL_W-1:0] a_s;
    logic [COL_W-1:0] b_s;
    logic [COL_W-1:0] c_s;
    assign a_s = rows_i[(3*g)*COL_W +: COL_W];
    assign b_s = rows_i[(3*g+1)*COL_W +: COL_W];
    assign c_s = rows_i[(3*g+2)*COL_W +: COL_W];
    assign rows_o[(2*g)*COL_W +: COL_W]   = a_s ^ b_s ^ c_s;
    assign rows_o[(2*g+1)*COL_W +: COL_W] = ((a_s & b_s) | (a_s & c_s) | (b_s & c_s)) << 1;
  end

  for (genvar k = 0; k < LEFT; k++) begin : g_pass
    assign rows_o[(2*GROUPS+k)*COL_W +: COL_W] = rows_i[(3*GROUPS+k)*COL_W +: COL_W];
  end

endmodule

// File: rtl/pipelined_wallace_multiplier.sv
// Three-stage Wallace-tree multiplier with valid/ready handshake, per-op
// signed (Baugh-Wooley) or unsigned mode, and a passthrough tag.
module pipelined_wallace_multiplier
  import wallace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int PROD_W = prod_w(WIDTH);
  localparam int N0     = pp_rows(WIDTH);
  localparam int L_ALL  = wallace_layers(WIDTH);
  localparam int L_S1   = split_layer(WIDTH);
  localparam int L_S2   = L_ALL - L_S1;
  localparam int R1     = rows_after(N0, L_S1);
  localparam logic [PROD_W-1:0] BW_CONST = PROD_W'(bw_const(WIDTH));

  logic                       v1_q, v2_q, v3_q;
  logic                       adv_d;
  logic [N0-1:0][PROD_W-1:0]  pp_d;
  logic [R1*PROD_W-1:0]       s1_rows_d, s1_rows_q;
  logic [PROD_W-1:0]          sum_d, carry_d, sum_q, carry_q;
  logic [PROD_W-1:0]          p_d, out_p_q, c_d;
  logic [TAG_W-1:0]           s1_tag_q, s2_tag_q, out_tag_q;

  assign adv_d     = !v3_q || out_ready;
  assign in_ready  = adv_d;
  assign out_valid = v3_q;
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;

  // Signed mode inverts the cross terms that involve exactly one operand MSB.
  always_comb begin
    pp_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_d[i][i+j] = (in_x[j] & in_y[i]) ^ (in_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
      end
    end
    pp_d[WIDTH] = in_signed ? BW_CONST : {PROD_W{1'b0}};
  end

  for (genvar l = 0; l < L_S1; l++) begin : g_s1
    localparam int RI = rows_after(N0, l);
    logic [csa_rows_out(RI)*PROD_W-1:0] rows_s;
    if (l == 0) begin : g_first
      wallace_csa_layer #(.ROWS_IN(RI), .COL_W(PROD_W)) u_csa (.rows_i(pp_d), .rows_o(rows_s));
    end else begin : g_next
      wallace_csa_layer #(.ROWS_IN(RI), .COL_W(PROD_W)) u_csa (.rows_i(g_s1[l-1].rows_s), .rows_o(rows_s));
    end
  end
  assign s1_rows_d = g_s1[L_S1-1].rows_s;

  for (genvar l = 0; l < L_S2; l++) begin : g_s2
    localparam int RI = rows_after(R1, l);
    logic [csa_rows_out(RI)*PROD_W-1:0] rows_s;
    if (l == 0) begin : g_first
      wallace_csa_layer #(.ROWS_IN(RI), .COL_W(PROD_W)) u_csa (.rows_i(s1_rows_q), .rows_o(rows_s));
    end else begin : g_next
      wallace_csa_layer #(.ROWS_IN(RI), .COL_W(PROD_W)) u_csa (.rows_i(g_s2[l-1].rows_s), .rows_o(rows_s));
    end
  end
  assign sum_d   = g_s2[L_S2-1].rows_s[PROD_W-1:0];
  assign carry_d = g_s2[L_S2-1].rows_s[2*PROD_W-1:PROD_W];

  // Final ripple-carry add; the carry out of the top column is dropped.
  always_comb begin
    c_d = '0;
    for (int k = 0; k < PROD_W - 1; k++) begin
      c_d[k+1] = (sum_q[k] & carry_q[k]) | (sum_q[k] & c_d[k]) | (carry_q[k] & c_d[k]);
    end
    p_d = sum_q ^ carry_q ^ c_d;
  end

  // All stages move together on adv; data registers load only behind a valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_rows_q <= '0;
      s1_tag_q  <= '0;
      sum_q     <= '0;
      carry_q   <= '0;
      s2_tag_q  <= '0;
      out_p_q   <= '0;
      out_tag_q <= '0;
    end else if (adv_d) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (in_valid) begin
        s1_rows_q <= s1_rows_d;
        s1_tag_q  <= in_tag;
      end
      if (v1_q) begin
        sum_q    <= sum_d;
        carry_q  <= carry_d;
        s2_tag_q <= s1_tag_q;
      end
      if (v2_q) begin
        out_p_q   <= p_d;
        out_tag_q <= s2_tag_q;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// Scoreboard bench for the pipelined Wallace multiplier at WIDTH=8.
module tb_pipelined_wallace_multiplier;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_x = '0;
  logic [W-1:0]  in_y = '0;
  logic          in_signed = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_p;
  logic [TW-1:0] out_tag;

  typedef struct {
    logic [TW-1:0] tag;
    logic [PW-1:0] p;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_out   = 0;
  bit   lat_chk = 1'b0;

  always #5 clk = ~clk;

  pipelined_wallace_multiplier #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag)
  );

  function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [PW-1:0] xe;
    logic [PW-1:0] ye;
    xe = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ye = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, then judge both handshakes before the posedge.
  task automatic tick(input logic r, input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic s, input logic [TW-1:0] tag, input logic rdy,
                      input logic [PW-1:0] exp_p, output logic acc);
    @(negedge clk);
    rst = r; in_valid = v; in_x = x; in_y = y; in_signed = s; in_tag = tag; out_ready = rdy;
    #1;
    cyc++;
    acc = 1'b0;
    if (r) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          check_eq("out_p", 64'(out_p), 64'(sb[0].p));
          check_eq("out_tag", 64'(out_tag), 64'(sb[0].tag));
          if (out_ready) begin
            if (lat_chk) check_eq("latency", 64'(cyc - sb[0].cyc), 64'd3);
            void'(sb.pop_front());
            n_out++;
          end
        end
      end
      if (v && in_ready) begin
        sb.push_back('{tag: tag, p: exp_p, cyc: cyc});
        acc = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic rdy);
    logic a;
    tick(1'b0, 1'b0, '0, '0, 1'b0, '0, rdy, '0, a);
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                    input logic [TW-1:0] tag, input logic [PW-1:0] e);
    logic a;
    tick(1'b0, 1'b1, x, y, s, tag, 1'b1, e, a);
    check_eq("accept", 64'(a), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      idle(1'b1);
    end
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic          a;
    logic          bp_saw_stall;
    int            issued;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          s;
    logic [TW-1:0] tg;

    tick(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, a);
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, a);
    idle(1'b1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_p", 64'(out_p), 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed values with an always-ready consumer: exact 3-cycle latency.
    lat_chk = 1'b1;
    op(8'hFF, 8'hFF, 1'b0, 4'h5, 16'hFE01);
    drain();
    op(8'h80, 8'h80, 1'b1, 4'h1, 16'h4000);
    op(8'hFF, 8'h01, 1'b1, 4'h2, 16'hFFFF);
    op(8'h80, 8'h7F, 1'b1, 4'h3, 16'hC080);
    drain();
    for (int i = 0; i < 4; i++) begin
      op(8'h80, 8'h02, 1'(i % 2), 4'(i + 6), (i % 2 == 1) ? 16'hFF00 : 16'h0100);
    end
    drain();
    lat_chk = 1'b0;

    // Backpressure: consumer stalls for five cycles while five ops are issued.
    n_out = 0;
    issued = 0;
    bp_saw_stall = 1'b0;
    for (int k = 0; k < 30; k++) begin
      x  = 8'(issued * 37 + 3);
      y  = 8'(issued * 91 + 200);
      s  = 1'(issued % 2);
      tg = 4'(issued + 8);
      tick(1'b0, (issued < 5), x, y, s, tg, !(k >= 3 && k <= 7), model(x, y, s), a);
      if (a) issued++;
      if (!in_ready) bp_saw_stall = 1'b1;
    end
    check_eq("bp_in_ready_drop", 64'(bp_saw_stall), 64'd1);
    check_eq("bp_delivered", 64'(n_out), 64'd5);
    check_eq("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Reset with three operations in flight: nothing from them may surface.
    op(8'h12, 8'h34, 1'b0, 4'hA, model(8'h12, 8'h34, 1'b0));
    op(8'hF0, 8'h0F, 1'b1, 4'hB, model(8'hF0, 8'h0F, 1'b1));
    op(8'h7F, 8'h7F, 1'b0, 4'hC, model(8'h7F, 8'h7F, 1'b0));
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, a);
    idle(1'b1);
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (6) idle(1'b1);
    check_eq("midrst_no_stale", 64'(sb.size()), 64'd0);

    // Random traffic, random mode, random valid/ready.
    n_out = 0;
    issued = 0;
    for (int k = 0; k < 3000; k++) begin
      x  = 8'($urandom);
      y  = 8'($urandom);
      s  = 1'($urandom_range(0, 1));
      tg = 4'($urandom);
      tick(1'b0, ($urandom_range(0, 3) != 0), x, y, s, tg, ($urandom_range(0, 3) != 0), model(x, y, s), a);
      if (a) issued++;
    end
    drain();
    check_eq("rand_count", 64'(n_out), 64'(issued));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
